// File: rtl/key_debouncer.sv
// Two-flop synchroniser, per-key stability filter and press/release pulses.
// Define KEY_AUTOREPEAT_EN to add held-key auto-repeat press pulses.
module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_param
    $error("key_debouncer: illegal parameter value");
  end

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_down;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [CW-1:0]       r_cnt [NUM_KEYS];

  logic [NUM_KEYS-1:0] w_pend;
  logic [NUM_KEYS-1:0] w_diff;
  logic [NUM_KEYS-1:0] w_flip;
  logic [NUM_KEYS-1:0] w_rep_fire;

  assign w_pend = ~r_sync2;
  assign w_diff = w_pend ^ r_down;

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_flip[i] = w_diff[i] && (r_cnt[i] == CMAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  // Any agreeing sample restarts the stability count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!w_diff[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_down    <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_down    <= r_down ^ w_flip;
      r_press   <= (w_flip & ~r_down) | w_rep_fire;
      r_release <= w_flip & r_down;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] RD_M1 = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_M1 = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]       r_rep [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_first;

  // A release edge always wins over a due repeat
  always_comb begin
    w_rep_fire = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_rep_fire[i] = r_down[i] && !w_flip[i] &&
        (r_rep[i] == (r_first[i] ? RD_M1 : RP_M1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first <= '1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_rep[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!r_down[i] || w_flip[i]) begin
          r_rep[i]   <= '0;
          r_first[i] <= 1'b1;
        end else if (w_rep_fire[i]) begin
          r_rep[i]   <= '0;
          r_first[i] <= 1'b0;
        end else begin
          r_rep[i] <= r_rep[i] + 1'b1;
        end
      end
    end
  end
`else
  assign w_rep_fire = '0;
`endif

  assign key_down    = r_down;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random bouncing keys,
// all checked each cycle against a streak/age based reference model.
module tb_key_debouncer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] KEY = '1;
  logic [N-1:0] key_down;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  int checks = 0;
  int failures = 0;

  key_debouncer #(
    .NUM_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .KEY(KEY),
    .key_down(key_down),
    .key_press(key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Reference model: key flips after D consecutive disagreeing samples
  // of the two-edge-delayed raw input; repeats derived from press age.
  logic [N-1:0] m_h1, m_h2, m_down, m_press, m_rel;
  int m_streak [N];
  int m_age [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_h1 = '1; m_h2 = '1;
      m_down = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin
        m_streak[i] = 0; m_age[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_press[i] = 1'b0;
        m_rel[i] = 1'b0;
        if (!m_h2[i] != m_down[i]) m_streak[i]++;
        else m_streak[i] = 0;
        if (m_streak[i] == D) begin
          m_streak[i] = 0;
          m_down[i] = ~m_down[i];
          if (m_down[i]) m_press[i] = 1'b1;
          else m_rel[i] = 1'b1;
          m_age[i] = 0;
        end else if (m_down[i]) begin
          m_age[i]++;
`ifdef KEY_AUTOREPEAT_EN
          if (m_age[i] == RD ||
              (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
            m_press[i] = 1'b1;
`endif
        end
      end
      m_h2 = m_h1;
      m_h1 = KEY;
    end
  end

  task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("model_down", key_down, m_down);
    chk("model_press", key_press, m_press);
    chk("model_release", key_release, m_rel);
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  int quiet;
  int np;
  int nr;
  int runleft [N];

  initial begin
    // Test 1: reset, then single press of key 0
    reset = 1'b1; KEY = '1;
    wait_n(3);
    reset = 1'b0;
    wait_n(1);
    chk("t1_reset_down", key_down, 4'b0000);
    chk("t1_reset_press", key_press, 4'b0000);
    wait_n(4);
    KEY[0] = 1'b0;
    wait_n(5);
    chk("t1_pre_accept", key_down, 4'b0000);
    wait_n(1);
    chk("t1_down", key_down, 4'b0001);
    chk("t1_press", key_press, 4'b0001);
    chk("t1_no_rel", key_release, 4'b0000);
    wait_n(1);
    chk("t1_press_gone", key_press, 4'b0000);
    chk("t1_held", key_down, 4'b0001);
    KEY[0] = 1'b1;
    wait_n(6);
    chk("t1_rel", key_release, 4'b0001);
    chk("t1_rel_down", key_down, 4'b0000);
    wait_n(2);

    // Test 2: bounce shorter than the debounce window
    quiet = 0;
    for (int j = 0; j < 18; j++) begin
      KEY[2] = !((j < 3) || (j >= 4 && j < 7));
      @(negedge clk);
      if ((key_down | key_press | key_release) != 0) quiet++;
    end
    chk_int("t2_glitch_quiet", quiet, 0);

    // Test 3: two keys pressed on the same edge
    KEY = 4'b0101;
    wait_n(6);
    chk("t3_press", key_press, 4'b1010);
    wait_n(1);
    chk("t3_down", key_down, 4'b1010);
    chk("t3_press_gone", key_press, 4'b0000);
    wait_n(13);
    KEY = 4'b1111;
    wait_n(5);
    chk("t3_pre_rel", key_release, 4'b0000);
    wait_n(1);
    chk("t3_rel", key_release, 4'b1010);
    wait_n(1);
    chk("t3_rel_gone", key_release, 4'b0000);
    wait_n(2);

    // Test 4: reset while a key is held
    KEY[0] = 1'b0;
    wait_n(6);
    chk("t4_accept", key_down, 4'b0001);
    wait_n(2);
    reset = 1'b1;
    #1;
    chk("t4_async_clear", key_down, 4'b0000);
    chk("t4_no_rel", key_release, 4'b0000);
    wait_n(2);
    reset = 1'b0;
    wait_n(5);
    chk("t4_not_yet", key_down, 4'b0000);
    wait_n(1);
    chk("t4_reaccept", key_down, 4'b0001);
    chk("t4_repress", key_press, 4'b0001);
    KEY[0] = 1'b1;
    wait_n(10);

    // Tests 5/6: long hold of key 2, count press/release pulses
    np = 0; nr = 0;
    KEY[2] = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (key_press[2]) np++;
      if (key_release[2]) nr++;
      if (j == 24) KEY[2] = 1'b1;
    end
`ifdef KEY_AUTOREPEAT_EN
    chk_int("t5_press_count", np, 6);
`else
    chk_int("t6_press_count", np, 1);
`endif
    chk_int("t56_release_count", nr, 1);

    // Random bouncing keys with occasional resets
    for (int i = 0; i < N; i++) runleft[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (runleft[i] == 0) begin
          KEY[i] = ~KEY[i];
          runleft[i] = ($urandom_range(0, 2) == 0) ?
                       int'($urandom_range(0, 4)) :
                       int'($urandom_range(4, 40));
        end else begin
          runleft[i]--;
        end
      end
    end
    reset = 1'b0;
    KEY = '1;
    wait_n(12);
    chk("end_idle", key_down, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
